// File: rtl/general_register_file_pkg.sv
// general_register_file_pkg
// Shared definitions for the general register file: FunSel operation codes,
// read-port select indices and the default data width.
// Optional feature macro used by the design: REGFILE_SAT_EN (saturating
// increment/decrement instead of wrapping).
package general_register_file_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Operation applied to every enabled register on a clock edge.
    typedef enum logic [2:0] {
        DEC       = 3'b000,  // Q <- Q - 1
        INC       = 3'b001,  // Q <- Q + 1
        LOAD      = 3'b010,  // Q <- I
        CLR       = 3'b011,  // Q <- 0
        CLR_WRLO8 = 3'b100,  // Q <- {0, I[7:0]}
        WRLO8     = 3'b101,  // Q[7:0] <- I[7:0]
        WRLO16    = 3'b110,  // Q[15:0] <- I[15:0]
        SHL8_WR   = 3'b111   // Q <- {Q[23:0], I[7:0]}
    } fun_sel_e;

    // Read-port select encoding: general registers first, scratch after.
    localparam logic [2:0] SEL_R1 = 3'd0;
    localparam logic [2:0] SEL_R2 = 3'd1;
    localparam logic [2:0] SEL_R3 = 3'd2;
    localparam logic [2:0] SEL_R4 = 3'd3;
    localparam logic [2:0] SEL_S1 = 3'd4;
    localparam logic [2:0] SEL_S2 = 3'd5;
    localparam logic [2:0] SEL_S3 = 3'd6;
    localparam logic [2:0] SEL_S4 = 3'd7;

endpackage

// File: rtl/general_register_file_if.sv
// general_register_file_if
// Bus between the datapath controller and the register file.
//   I        write data
//   FunSel   operation for all enabled registers
//   RegSel   enables for R1..R4 (bit 0 = R1)
//   ScrSel   enables for S1..S4 (bit 0 = S1)
//   OutASel  read-port A select (0-3 = R1-R4, 4-7 = S1-S4)
//   OutBSel  read-port B select, same encoding
//   OutA/B   combinational read data toward the ALU
// There is no valid/ready handshake: a write happens on every rising edge for
// each register whose enable bit is high, and reads are purely combinational.
// Feature macro affecting the register file: REGFILE_SAT_EN.
interface general_register_file_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] I;
    logic [2:0]       FunSel;
    logic [3:0]       RegSel;
    logic [3:0]       ScrSel;
    logic [2:0]       OutASel;
    logic [2:0]       OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;

    // Controller side: drives writes and selects, consumes read data.
    modport master (
        output I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        input  OutA, OutB
    );

    // Register file side.
    modport slave (
        input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        output OutA, OutB
    );
endinterface

// File: rtl/general_register_file_gp_register.sv
// gp_register
// One WIDTH-bit register implementing the FunSel operation table.
// Ports:
//   Clock   rising-edge clock
//   Reset   synchronous active-high clear, overrides E and FunSel
//   E       enable; when low the register holds
//   FunSel  operation code (see general_register_file_pkg::fun_sel_e)
//   I       write data
//   Q       register contents
// Macro REGFILE_SAT_EN: when defined, INC of all-ones and DEC of zero hold
// their value; otherwise they wrap.
module gp_register
    import general_register_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] next_q;

`ifdef REGFILE_SAT_EN
    assign inc_val = (&Q)  ? Q : Q + WIDTH'(1);
    assign dec_val = (~|Q) ? Q : Q - WIDTH'(1);
`else
    assign inc_val = Q + WIDTH'(1);
    assign dec_val = Q - WIDTH'(1);
`endif

    always_comb begin
        next_q = Q;
        case (fun_sel_e'(FunSel))
            DEC:       next_q = dec_val;
            INC:       next_q = inc_val;
            LOAD:      next_q = I;
            CLR:       next_q = '0;
            CLR_WRLO8: next_q = {{(WIDTH-8){1'b0}}, I[7:0]};
            WRLO8:     next_q = {Q[WIDTH-1:8], I[7:0]};
            WRLO16:    next_q = {Q[WIDTH-1:16], I[15:0]};
            SHL8_WR:   next_q = {Q[WIDTH-9:0], I[7:0]};
            default:   next_q = Q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (E) begin
            Q <= next_q;
        end
    end

endmodule

// File: rtl/general_register_file.sv
// general_register_file
// Eight-entry register file (R1-R4, S1-S4) feeding the ALU A/B operands.
// Ports:
//   Clock  rising-edge clock
//   Reset  synchronous active-high, clears all eight registers
//   bus    general_register_file_if.slave: write data, FunSel, RegSel,
//          ScrSel, read selects and the two combinational read ports
// Macro REGFILE_SAT_EN: saturating increment/decrement (default wraps).
// Reads show the pre-edge value during a write cycle; there is no forwarding.
module general_register_file
    import general_register_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    general_register_file_if.slave bus
);

    // Index 0-3 = R1-R4, 4-7 = S1-S4, matching the read-select encoding.
    logic [7:0]       enables;
    logic [WIDTH-1:0] q [8];

    assign enables = {bus.ScrSel, bus.RegSel};

    for (genvar k = 0; k < 8; k++) begin : g_reg
        gp_register #(
            .WIDTH (WIDTH)
        ) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (enables[k]),
            .FunSel (bus.FunSel),
            .I      (bus.I),
            .Q      (q[k])
        );
    end

    assign bus.OutA = q[bus.OutASel];
    assign bus.OutB = q[bus.OutBSel];

endmodule

// File: tb/tb_general_register_file.sv
// tb_general_register_file
// Self-checking bench for general_register_file. Honours REGFILE_SAT_EN
// when the same macro is defined for the build.
module tb_general_register_file;
    import general_register_file_pkg::*;

    logic clk;
    logic rst;

    general_register_file_if #(.WIDTH(32)) bus ();

    general_register_file #(.WIDTH(32)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model [8];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one register for one FunSel.
    function automatic logic [31:0] model_op(input logic [31:0] q, input logic [2:0] fs,
                                             input logic [31:0] d);
        logic [31:0] r;
        case (fs)
`ifdef REGFILE_SAT_EN
            3'b000: r = (q == 32'h0) ? q : q - 32'h1;
            3'b001: r = (q == 32'hFFFF_FFFF) ? q : q + 32'h1;
`else
            3'b000: r = q - 32'h1;
            3'b001: r = q + 32'h1;
`endif
            3'b010: r = d;
            3'b011: r = 32'h0;
            3'b100: r = {24'h0, d[7:0]};
            3'b101: r = {q[31:8], d[7:0]};
            3'b110: r = {q[31:16], d[15:0]};
            default: r = {q[23:0], d[7:0]};
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [3:0] rs, input logic [3:0] ss,
                            input logic [2:0] fs, input logic [31:0] d);
        @(negedge clk);
        rst = 1'b1;
        bus.RegSel = rs; bus.ScrSel = ss; bus.FunSel = fs; bus.I = d;
        @(posedge clk);
        for (int k = 0; k < 8; k++) model[k] = 32'h0;
        #1;
        rst = 1'b0;
        bus.RegSel = 4'h0; bus.ScrSel = 4'h0;
    endtask

    task automatic do_op(input logic [3:0] rs, input logic [3:0] ss,
                         input logic [2:0] fs, input logic [31:0] d);
        logic [7:0] en;
        @(negedge clk);
        bus.RegSel = rs; bus.ScrSel = ss; bus.FunSel = fs; bus.I = d;
        en = {ss, rs};
        @(posedge clk);
        for (int k = 0; k < 8; k++)
            if (en[k]) model[k] = model_op(model[k], fs, d);
        #1;
        bus.RegSel = 4'h0; bus.ScrSel = 4'h0;
    endtask

    // Push an expectation for register idx on port A and port B, then read.
    task automatic read_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] e;
        bus.OutASel = idx;
        bus.OutBSel = idx;
        exp_q.push_back(exp);
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_A"}, bus.OutA, e);
        e = exp_q.pop_front();
        check_eq({tag, "_B"}, bus.OutB, e);
    endtask

    // Check all eight registers against the model, A and B on different selects.
    task automatic check_all(input string tag);
        logic [31:0] e;
        for (int k = 0; k < 8; k++) begin
            bus.OutASel = 3'(k);
            bus.OutBSel = 3'(7 - k);
            exp_q.push_back(model[k]);
            exp_q.push_back(model[7 - k]);
            #1;
            e = exp_q.pop_front();
            check_eq($sformatf("%s_A%0d", tag, k), bus.OutA, e);
            e = exp_q.pop_front();
            check_eq($sformatf("%s_B%0d", tag, 7 - k), bus.OutB, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] e;
        rst = 1'b0;
        bus.I = '0; bus.FunSel = 3'b000; bus.RegSel = 4'h0; bus.ScrSel = 4'h0;
        bus.OutASel = 3'd0; bus.OutBSel = 3'd0;

        // Reset clears everything.
        do_reset(4'h0, 4'h0, 3'b000, 32'h0);
        for (int k = 0; k < 8; k++) read_chk("reset", 3'(k), 32'h0);

        // Load each register one-hot with 0x11111111 * index.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] oh;
            oh = 8'h1 << k;
            do_op(oh[3:0], oh[7:4], LOAD, 32'h1111_1111 * (k + 1));
        end
        for (int k = 0; k < 8; k++) read_chk("load", 3'(k), 32'h1111_1111 * (k + 1));
        check_all("load_x");

        // Increment of all-ones and decrement of zero.
        do_op(4'b0001, 4'h0, LOAD, 32'hFFFF_FFFF);
        do_op(4'b0001, 4'h0, INC, 32'h0);
`ifdef REGFILE_SAT_EN
        read_chk("inc_max", SEL_R1, 32'hFFFF_FFFF);
`else
        read_chk("inc_max", SEL_R1, 32'h0000_0000);
`endif
        do_op(4'b0010, 4'h0, CLR, 32'h0);
        do_op(4'b0010, 4'h0, DEC, 32'h0);
`ifdef REGFILE_SAT_EN
        read_chk("dec_zero", SEL_R2, 32'h0000_0000);
`else
        read_chk("dec_zero", SEL_R2, 32'hFFFF_FFFF);
`endif

        // Partial-width operations on R3.
        do_op(4'b0100, 4'h0, LOAD, 32'hAABB_CCDD);
        do_op(4'b0100, 4'h0, CLR_WRLO8, 32'h1234_5678);
        read_chk("clr_wrlo8", SEL_R3, 32'h0000_0078);
        do_op(4'b0100, 4'h0, LOAD, 32'hAABB_CCDD);
        do_op(4'b0100, 4'h0, WRLO8, 32'h1234_5678);
        read_chk("wrlo8", SEL_R3, 32'hAABB_CC78);
        do_op(4'b0100, 4'h0, LOAD, 32'hAABB_CCDD);
        do_op(4'b0100, 4'h0, WRLO16, 32'h1234_5678);
        read_chk("wrlo16", SEL_R3, 32'hAABB_5678);
        do_op(4'b0100, 4'h0, LOAD, 32'hAABB_CCDD);
        do_op(4'b0100, 4'h0, SHL8_WR, 32'h1234_5678);
        read_chk("shl8", SEL_R3, 32'hBBCC_DD78);
        check_all("partial");

        // Clear all eight at once.
        do_op(4'hF, 4'hF, CLR, 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++) read_chk("clr_all", 3'(k), 32'h0);

        // Read-during-write on R4: old value in the write cycle, new after.
        do_op(4'b1000, 4'h0, LOAD, 32'h0BAD_F00D);
        @(negedge clk);
        bus.OutASel = SEL_R4;
        bus.RegSel = 4'b1000; bus.ScrSel = 4'h0; bus.FunSel = LOAD; bus.I = 32'hDEAD_BEEF;
        exp_q.push_back(32'h0BAD_F00D);
        #1;
        e = exp_q.pop_front();
        check_eq("rdw_old", bus.OutA, e);
        @(posedge clk);
        model[3] = 32'hDEAD_BEEF;
        #1;
        bus.RegSel = 4'h0;
        exp_q.push_back(32'hDEAD_BEEF);
        e = exp_q.pop_front();
        check_eq("rdw_new", bus.OutA, e);

        // Reset in the middle of a byte-assembly sequence.
        do_op(4'b0001, 4'h0, SHL8_WR, 32'h0000_0012);
        do_op(4'b0001, 4'h0, SHL8_WR, 32'h0000_0034);
        do_reset(4'h0, 4'h0, SHL8_WR, 32'h0000_0056);
        read_chk("mid_rst", SEL_R1, 32'h0);
        do_op(4'b0001, 4'h0, SHL8_WR, 32'h0000_00AB);
        read_chk("post_rst_shl", SEL_R1, 32'h0000_00AB);

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), $urandom);
            if (n % 8 == 7) check_all($sformatf("rand%0d", n));
        end

        // Reset wins over an all-enabled load.
        do_op(4'hF, 4'hF, LOAD, 32'h5A5A_5A5A);
        do_reset(4'hF, 4'hF, LOAD, 32'hCAFE_BABE);
        for (int k = 0; k < 8; k++) read_chk("rst_over_load", 3'(k), 32'h0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/general_register_file.md
# general_register_file

Eight-entry, 32-bit register file (general registers R1–R4, scratch registers S1–S4) that sits directly upstream of the arithmetic logic unit. It supplies the ALU's A and B operands through two independent combinational read ports. It accepts writes from the datapath input bus under per-register function-select control. Each selected register performs one update per clock: load, clear, increment, decrement, or a partial-width write.

## Interface
Parameters:
- WIDTH, 32, register and port data width; the ALU consumes 32-bit operands.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; clears all eight registers on the next rising edge.
- I  input  WIDTH  write data bus.
- FunSel  input  3  operation applied to every enabled register.
- RegSel  input  4  active-high enables; bit 0 = R1 … bit 3 = R4.
- ScrSel  input  4  active-high enables; bit 0 = S1 … bit 3 = S4.
- OutASel  input  3  read-port A select: 0–3 = R1–R4, 4–7 = S1–S4.
- OutBSel  input  3  read-port B select, same encoding.
- OutA  output  WIDTH  selected register contents; drives ALU A.
- OutB  output  WIDTH  selected register contents; drives ALU B.

## Operation
FunSel encoding (Q = selected register):
- 000 decrement: Q ← Q − 1.
- 001 increment: Q ← Q + 1.
- 010 load: Q ← I.
- 011 clear: Q ← 0.
- 100 clear-and-write-byte: Q[31:8] ← 0, Q[7:0] ← I[7:0].
- 101 write low byte only: Q[7:0] ← I[7:0]; Q[31:8] is held.
- 110 write low half: Q[15:0] ← I[15:0]; Q[31:16] is held.
- 111 shift-in byte: Q ← {Q[23:0], I[7:0]}.

Update rules:
- A register whose enable bit is 0 holds its value.
- Any number of registers may be enabled at once. All enabled registers apply the same FunSel in parallel, each using its own prior value.
- Reads are purely combinational. OutA and OutB may select the same register.
- Increment and decrement arithmetic is modulo 2^WIDTH unless REGFILE_SAT_EN is defined.

## Timing
- Reset asserted at a rising edge sets all registers to 0. Reset overrides every enable and FunSel. OutA and OutB therefore read 0 after that edge.
- Reset asserted partway through a multi-cycle sequence (for example, repeated 111 byte assembly) discards the partial value. No state survives reset.
- Write latency is one cycle. The new value is visible on OutA/OutB after the edge that performed the write.
- Read-during-write: in the cycle a register is written, a port selecting it shows the old value. There is no forwarding.
- Read latency is zero: the ports respond combinationally to OutASel/OutBSel.
- Power-up contents before the first reset are undefined. The bench must apply Reset first.

## Configuration
REGFILE_SAT_EN
- Defined: increment of all-ones holds all-ones; decrement of 0 holds 0.
- Undefined: both wrap (0xFFFFFFFF + 1 = 0; 0 − 1 = 0xFFFFFFFF).
- All other operations are identical in both builds.

## Structure
- Shared package contents:
  - FunSel encodings as named constants (DEC, INC, LOAD, CLR, CLR_WRLO8, WRLO8, WRLO16, SHL8_WR).
  - OutSel index constants for R1–R4 and S1–S4.
  - The WIDTH default.
- Sub-module gp_register: one WIDTH-bit register with Clock, Reset, enable E, FunSel, I inputs and a Q output, implementing the FunSel table and the saturation option.
  - The file instantiates eight of these.
  - Two 8:1 read multiplexers drive OutA and OutB.

## Test plan
- Reset, then load each register (RegSel/ScrSel one-hot, FunSel=010) with I = 0x11111111 × index → every register reads back its value on OutA and OutB for all selects.
- R1 = 0xFFFFFFFF, FunSel=001 → R1 = 0x00000000 (wrapping build) or 0xFFFFFFFF (REGFILE_SAT_EN). Same check for R2 = 0 with FunSel=000: expect 0xFFFFFFFF or 0.
- R3 = 0xAABBCCDD, I = 0x12345678:
  - FunSel=100 → 0x00000078.
  - Reload, FunSel=101 → 0xAABBCC78.
  - Reload, FunSel=110 → 0xAABB5678.
  - Reload, FunSel=111 → 0xBBCCDD78.
- RegSel=1111, ScrSel=1111, FunSel=011 → all eight registers 0 one cycle later.
- Read-during-write: OutASel=R4, load R4 with 0xDEADBEEF → OutA shows the old value in the write cycle and 0xDEADBEEF after the edge.
- Reset asserted together with FunSel=010 and all enables → all registers 0 after the edge, not I.
